pptree_pipe_adder: RTL
======================

// Module: pptree_pipe_adder
// PURPOSE
//   Pipelined, parametrised Kogge-Stone parallel-prefix adder/subtractor built only from the
//   cell-mapping primitives (and2, ao21, xor2, inverter, ...), so the same RTL retargets any mapped lib.
//   Generalises the single-cycle prefix trees: configurable width and pipeline depth,
//   add/sub mode, and a valid/ready stream interface with backpressure. Sits at datapath-tile level.
// PARAMETERS
//   WIDTH   32  operand width in bits; any value >= 2
//   STAGES  2   pipeline register ranks; legal range 1 .. LEVELS+1, where LEVELS = $clog2(WIDTH)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      block can accept a beat this cycle
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_cin     in   1      carry-in (ignored when in_sub=1)
//   in_sub     in   1      1: A - B (B inverted, carry-in forced to 1)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   out_sum    out  WIDTH  sum / difference, modulo 2^WIDTH
//   out_cout   out  1      carry-out (for sub: 1 = no borrow)
//   out_ovf    out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset: all valid flags 0, all data registers 0; outputs therefore out_valid=0, out_sum=0,
//     out_cout=0, out_ovf=0, in_ready=1 on the first cycle after reset release.
//   - Reset mid-operation: every in-flight beat is discarded; no partial result is ever presented.
//   - Handshake: a beat transfers when in_valid & in_ready; a result transfers when out_valid & out_ready.
//     out_* stay stable while out_valid & !out_ready.
//   - Stall: stall = out_valid & !out_ready. in_ready = !stall. The whole pipe advances only on !stall;
//     bubbles are not compressed (global-enable pipeline).
//   - Latency: exactly STAGES cycles from an accepted beat to its out_valid, absent stalls.
//     Throughput: one beat per cycle. Order preserved.
//   - Simultaneous accept and drain (out_valid & out_ready & in_valid) accepts the new beat in the same cycle.
//   - Datapath:
//     - Level 0: b' = in_b ^ {WIDTH{in_sub}}, c0 = in_sub | in_cin,
//       g_i = a_i & b'_i, p_i = a_i ^ b'_i.
//     - Bit-0 generate folds c0: G_0 = g_0 | (p_0 & c0).
//     - Prefix levels l = 1..LEVELS, span 2^(l-1): black cell (G,P) = (Gh | Ph&Gl, Ph&Pl);
//       pass-through where i < span.
//     - sum_i = p_i ^ G_{i-1} (sum_0 = p_0 ^ c0); cout = G_{W-1}; ovf = G_{W-2} ^ G_{W-1}.
//   - Register placement: rank 1 always captures the level-0 p/g/c0 signals. The remaining STAGES-1
//     ranks follow prefix level floor(k*LEVELS/(STAGES-1)), k = 1..STAGES-1. The final rank drives
//     the out_* ports (registered outputs).
//   - Illegal STAGES or WIDTH < 2: elaboration error via generate-time $error.
// STRUCTURE
//   - Shared package pptree_pkg:
//     - function clog2-based prefix_levels(WIDTH)
//     - function stage_after_level(k, LEVELS, STAGES)
//     - typedef gp_t {g, p} used for (G,P) pairs
//   - Sub-module pptree_black_cell (ao21 + and2), with a grey variant selected by parameter GREY = 1
//     (G only). Instantiated by generate loops.
//   - The top holds the valid/stall control and pipeline registers.
// TESTING
//   - WIDTH=32, STAGES=2, out_ready=1: A=0xFFFF_FFFF, B=1, cin=0, add
//       -> 2 cycles later sum=0, cout=1, ovf=0.
//   - Sub: A=0x8000_0000, B=1
//       -> sum=0x7FFF_FFFF, cout=1, ovf=1. A=3, B=5 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
//   - Backpressure: stream 8 beats (A=i, B=i) with out_ready low in cycles 3-6
//       -> in_ready low those cycles, out_sum held stable, results 0,2,..,14 in order, none dropped.
//   - Reset mid-flight: assert rst_n=0 with 2 beats in pipe
//       -> out_valid=0 immediately (async). After release, no stale beat appears; first new beat
//          emerges after STAGES cycles.
//   - Sweep WIDTH in {2,7,16,64} x all legal STAGES with 10k random beats vs A+B+cin reference model
//       -> zero mismatches; latency==STAGES.
//   - Corner: WIDTH=7, A=0x3F, B=0x01 add -> sum=0x40, cout=0, ovf=1.

Source files
------------

// File: rtl/pptree_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Kogge-Stone adder.
package pptree_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int prefix_levels(input int width);
        return $clog2(width);
    endfunction

    // Prefix level after which pipeline rank k+1 sits (rank 1 is always level 0).
    function automatic int stage_after_level(input int k, input int levels, input int stages);
        if (stages < 2) begin
            return levels;
        end
        return (k * levels) / (stages - 1);
    endfunction

    // True when the (G,P) vector leaving prefix level lvl is registered inside the tree.
    // The final rank is the output register and is not reported here.
    function automatic bit is_reg_level(input int lvl, input int levels, input int stages);
        if (stages < 2) begin
            return 1'b0;
        end
        if (lvl == 0) begin
            return 1'b1;
        end
        for (int k = 1; k <= stages - 2; k++) begin
            if (stage_after_level(k, levels, stages) == lvl) begin
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/pptree_black_cell.sv
// Prefix combine cell: ao21 for G and and2 for P; the grey variant only resolves G.
module pptree_black_cell
    import pptree_pkg::*;
#(
    parameter int GREY = 0
) (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);

    gp_t hi;
    gp_t lo;
    gp_t res;

    always_comb begin
        hi.g  = g_hi;
        hi.p  = p_hi;
        lo.g  = g_lo;
        lo.p  = p_lo;
        res.g = hi.g | (hi.p & lo.g);
        res.p = (GREY != 0) ? 1'b0 : (hi.p & lo.p);
    end

    assign g_out = res.g;
    assign p_out = res.p;

endmodule

// File: rtl/pptree_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready stream interface.
// The whole pipe moves on one global enable, so bubbles are kept, never squeezed out.
module pptree_pipe_adder
    import pptree_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int LEVELS = prefix_levels(WIDTH);

    if (WIDTH < 2) begin : g_bad_width
        $error("pptree_pipe_adder: WIDTH must be at least 2");
    end
    if (STAGES < 1 || STAGES > LEVELS + 1) begin : g_bad_stages
        $error("pptree_pipe_adder: STAGES must lie in 1 .. LEVELS+1");
    end

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_sum_q,   out_sum_d;
    logic             out_cout_q,  out_cout_d;
    logic             out_ovf_q,   out_ovf_d;
    logic             adv;

    assign adv      = ~(out_valid_q & ~out_ready);
    assign in_ready = adv;

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic [WIDTH-1:0] g_c, p_c, pp_c;
        logic             c0_c, v_c;
        logic [WIDTH-1:0] g_s, p_s, pp_s;
        logic             c0_s, v_s;
        logic             p_unused;

        // P bits of finished groups are dead; fold them into one sink net.
        assign p_unused = ^p_s;

        if (l == 0) begin : g_pg
            logic [WIDTH-1:0] b_eff, g_raw;
            logic             c0;

            assign b_eff = in_b ^ {WIDTH{in_sub}};
            assign c0    = in_sub | in_cin;
            assign g_raw = in_a & b_eff;
            assign p_c   = in_a ^ b_eff;
            assign g_c   = {g_raw[WIDTH-1:1], g_raw[0] | (p_c[0] & c0)};
            assign pp_c  = p_c;
            assign c0_c  = c0;
            assign v_c   = in_valid;
        end else begin : g_tree
            localparam int SPAN = 1 << (l - 1);

            assign pp_c = g_lvl[l-1].pp_s;
            assign c0_c = g_lvl[l-1].c0_s;
            assign v_c  = g_lvl[l-1].v_s;

            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if (i < SPAN) begin : g_pass
                    assign g_c[i] = g_lvl[l-1].g_s[i];
                    assign p_c[i] = g_lvl[l-1].p_s[i];
                end else begin : g_cell
                    pptree_black_cell #(
                        .GREY ((i < 2 * SPAN) ? 1 : 0)
                    ) u_cell (
                        .g_hi  (g_lvl[l-1].g_s[i]),
                        .p_hi  (g_lvl[l-1].p_s[i]),
                        .g_lo  (g_lvl[l-1].g_s[i-SPAN]),
                        .p_lo  (g_lvl[l-1].p_s[i-SPAN]),
                        .g_out (g_c[i]),
                        .p_out (p_c[i])
                    );
                end
            end
        end

        if (is_reg_level(l, LEVELS, STAGES)) begin : g_reg
            logic [WIDTH-1:0] g_q, g_d, p_q, p_d, pp_q, pp_d;
            logic             c0_q, c0_d, v_q, v_d;

            always_comb begin
                g_d  = g_q;
                p_d  = p_q;
                pp_d = pp_q;
                c0_d = c0_q;
                v_d  = v_q;
                if (adv) begin
                    g_d  = g_c;
                    p_d  = p_c;
                    pp_d = pp_c;
                    c0_d = c0_c;
                    v_d  = v_c;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    g_q  <= '0;
                    p_q  <= '0;
                    pp_q <= '0;
                    c0_q <= 1'b0;
                    v_q  <= 1'b0;
                end else begin
                    g_q  <= g_d;
                    p_q  <= p_d;
                    pp_q <= pp_d;
                    c0_q <= c0_d;
                    v_q  <= v_d;
                end
            end

            assign g_s  = g_q;
            assign p_s  = p_q;
            assign pp_s = pp_q;
            assign c0_s = c0_q;
            assign v_s  = v_q;
        end else begin : g_wire
            assign g_s  = g_c;
            assign p_s  = p_c;
            assign pp_s = pp_c;
            assign c0_s = c0_c;
            assign v_s  = v_c;
        end
    end

    logic [WIDTH-1:0] g_fin, pp_fin, sum_c;
    logic             c0_fin, v_fin;

    assign g_fin  = g_lvl[LEVELS].g_s;
    assign pp_fin = g_lvl[LEVELS].pp_s;
    assign c0_fin = g_lvl[LEVELS].c0_s;
    assign v_fin  = g_lvl[LEVELS].v_s;
    assign sum_c  = pp_fin ^ {g_fin[WIDTH-2:0], c0_fin};

    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;
        if (adv) begin
            out_valid_d = v_fin;
            out_sum_d   = sum_c;
            out_cout_d  = g_fin[WIDTH-1];
            out_ovf_d   = g_fin[WIDTH-2] ^ g_fin[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;

endmodule
